// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared ALU command, opcode and FSM state definitions
package core_pkg;

    typedef enum logic [1:0] {
        ALU_NONE = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_AND  = 2'd3
    } alu_command_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [2:0] FUNCT3_ADD = 3'b000;
    localparam logic [6:0] FUNCT7_ADD = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT      = 2'd2,
        ST_WRITEBACK = 2'd3
    } issue_state_t;

endpackage

// File: rtl/issue_retire_stage_instr_decoder.sv
// rtl/issue_retire_stage_instr_decoder.sv - combinational RV32I ADD/ADDI decoder
// Ports: instr in; legal, alu_op, rs1, rs2, rd, imm12, imm_sel out.
// rs2 is forced to 0 unless R-type, imm12 to 0 unless I-type.
module instr_decoder
    import core_pkg::*;
(
    input  logic [31:0]  instr,
    output logic         legal,
    output alu_command_t alu_op,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic [11:0]  imm12,
    output logic         imm_sel
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_addi;
    logic       is_add;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];

    assign is_addi = (opcode == OPC_OP_IMM) && (funct3 == FUNCT3_ADD);
    assign is_add  = (opcode == OPC_OP) && (funct3 == FUNCT3_ADD) && (funct7 == FUNCT7_ADD);

    assign legal   = is_addi || is_add;
    assign alu_op  = legal ? ALU_ADD : ALU_NONE;
    assign rs1     = instr[19:15];
    assign rs2     = is_add ? instr[24:20] : 5'd0;
    assign rd      = instr[11:7];
    assign imm12   = is_addi ? instr[31:20] : 12'd0;
    assign imm_sel = is_addi;

endmodule

// File: rtl/issue_retire_stage.sv
// rtl/issue_retire_stage.sv - single-in-flight issue/retire stage for the RV32I ALU
// Ports: clk, reset (async, active-high); instr_valid/instr_ready/instr fetch
// handshake; regfile read addresses, immediate, input_a_is_immediate, alu_op to
// the ALU; result_ready/alu_result back; regfile write port; illegal_instr
// pulse, sticky timeout_err, busy.
// Optional: ISSUE_RETIRE_INSTRET_EN adds the instret retire counter output.
module issue_retire_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    output logic [4:0]   regfile_rd0_addr,
    output logic [4:0]   regfile_rd1_addr,
    output logic [11:0]  immediate,
    output logic         input_a_is_immediate,
    output alu_command_t alu_op,
    input  logic         result_ready,
    input  logic [31:0]  alu_result,
    output logic         regfile_wr_en,
    output logic [4:0]   regfile_wr_addr,
    output logic [31:0]  regfile_wr_data,
    output logic         illegal_instr,
    output logic         timeout_err,
`ifdef ISSUE_RETIRE_INSTRET_EN
    output logic [31:0]  instret,
`endif
    output logic         busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    issue_state_t state, state_next;

    logic         dec_legal;
    alu_command_t dec_op;
    logic [4:0]   dec_rs1, dec_rs2, dec_rd;
    logic [11:0]  dec_imm;
    logic         dec_imm_sel;

    alu_command_t op_q;
    logic [4:0]   rs1_q, rs2_q, rd_q;
    logic [11:0]  imm_q;
    logic         imm_sel_q;
    logic [31:0]  result_q;
    logic [CNT_W-1:0] wait_cnt;
    logic         illegal_q;
    logic         timeout_q;

    logic         accept;
    logic         timeout_hit;

    instr_decoder u_decoder (
        .instr   (instr),
        .legal   (dec_legal),
        .alu_op  (dec_op),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .imm12   (dec_imm),
        .imm_sel (dec_imm_sel)
    );

    assign accept = instr_valid && (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the Moore outputs that depend only on the state register.
    always_comb begin
        state_next    = state;
        timeout_hit   = 1'b0;
        instr_ready   = 1'b0;
        busy          = 1'b1;
        alu_op        = ALU_NONE;
        regfile_wr_en = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid && dec_legal) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_op     = op_q;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (result_ready) begin
                    state_next = ST_WRITEBACK;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This WAIT cycle brings the count to TIMEOUT_CYCLES.
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                // x0 is never written but the instruction still retires.
                regfile_wr_en = (rd_q != 5'd0);
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= ALU_NONE;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            imm_q     <= 12'd0;
            imm_sel_q <= 1'b0;
            result_q  <= 32'd0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= accept && !dec_legal;
            // Illegal words leave the previously issued fields untouched.
            if (accept && dec_legal) begin
                op_q      <= dec_op;
                rs1_q     <= dec_rs1;
                rs2_q     <= dec_rs2;
                rd_q      <= dec_rd;
                imm_q     <= dec_imm;
                imm_sel_q <= dec_imm_sel;
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && !result_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == ST_WAIT && result_ready) begin
                result_q <= alu_result;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef ISSUE_RETIRE_INSTRET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= 32'd0;
        end else if (state == ST_WRITEBACK) begin
            instret <= instret + 32'd1;
        end
    end
`endif

    assign regfile_rd0_addr     = rs2_q;
    assign regfile_rd1_addr     = rs1_q;
    assign immediate            = imm_q;
    assign input_a_is_immediate = imm_sel_q;
    assign regfile_wr_addr      = rd_q;
    assign regfile_wr_data      = result_q;
    assign illegal_instr        = illegal_q;
    assign timeout_err          = timeout_q;

endmodule

// File: tb/tb_issue_retire_stage.sv
// tb/tb_issue_retire_stage.sv - self-checking bench for issue_retire_stage
module tb_issue_retire_stage;
    import core_pkg::*;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [31:0]  instr = 32'd0;
    logic [4:0]   regfile_rd0_addr;
    logic [4:0]   regfile_rd1_addr;
    logic [11:0]  immediate;
    logic         input_a_is_immediate;
    alu_command_t alu_op;
    logic         result_ready = 1'b0;
    logic [31:0]  alu_result = 32'd0;
    logic         regfile_wr_en;
    logic [4:0]   regfile_wr_addr;
    logic [31:0]  regfile_wr_data;
    logic         illegal_instr;
    logic         timeout_err;
    logic         busy;
`ifdef ISSUE_RETIRE_INSTRET_EN
    logic [31:0]  instret;
`endif

    int n_checks = 0;
    int n_pass = 0;

    logic        exp_timeout = 1'b0;
    logic [31:0] exp_instret = 32'd0;

    issue_retire_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .instr                (instr),
        .regfile_rd0_addr     (regfile_rd0_addr),
        .regfile_rd1_addr     (regfile_rd1_addr),
        .immediate            (immediate),
        .input_a_is_immediate (input_a_is_immediate),
        .alu_op               (alu_op),
        .result_ready         (result_ready),
        .alu_result           (alu_result),
        .regfile_wr_en        (regfile_wr_en),
        .regfile_wr_addr      (regfile_wr_addr),
        .regfile_wr_data      (regfile_wr_data),
        .illegal_instr        (illegal_instr),
        .timeout_err          (timeout_err),
`ifdef ISSUE_RETIRE_INSTRET_EN
        .instret              (instret),
`endif
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic chk_instret();
`ifdef ISSUE_RETIRE_INSTRET_EN
        chk("instret", instret, exp_instret);
`endif
    endtask

    // One transaction from an IDLE negedge back to an IDLE negedge.
    // delay < TO: result_ready in WAIT cycle 'delay'; delay >= TO: never.
    task automatic run_instr(input logic [31:0] w, input int delay, input logic [31:0] res);
        logic        is_i, is_r, legal, fire;
        logic [4:0]  e_rd0, e_rd1, e_rd;
        logic [11:0] e_imm;
        is_i  = (w[6:0] == 7'h13) && (w[14:12] == 3'd0);
        is_r  = (w[6:0] == 7'h33) && (w[14:12] == 3'd0) && (w[31:25] == 7'd0);
        legal = is_i || is_r;
        e_rd0 = is_r ? w[24:20] : 5'd0;
        e_rd1 = w[19:15];
        e_imm = is_i ? w[31:20] : 12'd0;
        e_rd  = w[11:7];

        chk("ready_idle", instr_ready, 1);
        instr_valid  = 1'b1;
        instr        = w;
        result_ready = 1'($urandom);
        alu_result   = $urandom;
        @(negedge clk);

        if (!legal) begin
            chk("illegal_pulse", illegal_instr, 1);
            chk("illegal_aluop", alu_op, ALU_NONE);
            chk("illegal_busy", busy, 0);
            chk("illegal_ready", instr_ready, 1);
            instr_valid = 1'b0;
            return;
        end

        chk("issue_aluop", alu_op, ALU_ADD);
        chk("issue_rd0", regfile_rd0_addr, e_rd0);
        chk("issue_rd1", regfile_rd1_addr, e_rd1);
        chk("issue_imm", immediate, e_imm);
        chk("issue_sel", input_a_is_immediate, is_i);
        chk("issue_busy", busy, 1);
        chk("issue_ready", instr_ready, 0);
        chk("issue_illegal", illegal_instr, 0);
        // Held valid with junk while busy: must not be taken.
        instr        = $urandom;
        result_ready = 1'($urandom);
        @(negedge clk);

        fire = 1'b0;
        for (int k = 0; k < TO; k++) begin
            chk("wait_aluop", alu_op, ALU_NONE);
            chk("wait_rd0", regfile_rd0_addr, e_rd0);
            chk("wait_rd1", regfile_rd1_addr, e_rd1);
            chk("wait_imm", immediate, e_imm);
            chk("wait_busy", busy, 1);
            chk("wait_wren", regfile_wr_en, 0);
            fire         = (k == delay);
            result_ready = fire;
            alu_result   = fire ? res : $urandom;
            @(negedge clk);
            if (fire) break;
        end

        if (fire) begin
            chk("wb_wren", regfile_wr_en, (e_rd != 5'd0));
            if (e_rd != 5'd0) begin
                chk("wb_addr", regfile_wr_addr, e_rd);
                chk("wb_data", regfile_wr_data, res);
            end
            chk("wb_busy", busy, 1);
            chk("wb_aluop", alu_op, ALU_NONE);
            instr_valid  = 1'b0;
            result_ready = 1'($urandom);
            exp_instret  = exp_instret + 32'd1;
            @(negedge clk);
            result_ready = 1'b0;
            chk("post_wb_busy", busy, 0);
            chk("post_wb_wren", regfile_wr_en, 0);
        end else begin
            exp_timeout = 1'b1;
            instr_valid = 1'b0;
            chk("to_busy", busy, 0);
            chk("to_wren", regfile_wr_en, 0);
        end
        result_ready = 1'b0;
        chk("sticky_timeout", timeout_err, exp_timeout);
        chk_instret();
    endtask

    initial begin
        logic [31:0] w;
        int          kind;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_aluop", alu_op, ALU_NONE);
        chk("rst_wren", regfile_wr_en, 0);
        chk("rst_rd0", regfile_rd0_addr, 0);
        chk("rst_rd1", regfile_rd1_addr, 0);
        chk("rst_imm", immediate, 0);
        chk("rst_sel", input_a_is_immediate, 0);
        chk("rst_waddr", regfile_wr_addr, 0);
        chk("rst_wdata", regfile_wr_data, 0);
        chk("rst_illegal", illegal_instr, 0);
        chk("rst_timeout", timeout_err, 0);
        chk_instret();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", instr_ready, 1);

        // Directed plan
        run_instr(32'hFFF08293, 0, 32'h00001234);   // ADDI x5,x1,-1
        run_instr(32'h002081B3, 0, 32'hCAFEF00D);   // ADD x3,x1,x2
        run_instr(32'h00000013, 0, 32'h55555555);   // NOP
        run_instr(32'h00000000, 0, 32'h0);          // illegal
        run_instr(32'hFFF08293, 1, 32'h00000042);   // back-to-back ADDI
        run_instr(32'h002081B3, TO, 32'h0);         // timeout
        run_instr(32'h00A50593, TO - 1, 32'h77);    // good after timeout, last WAIT cycle
        run_instr(32'h402081B3, 0, 32'h0);          // SUB encoding: illegal here

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            w    = $urandom;
            case (kind)
                0: w = {w[31:15], 3'b000, w[11:7], 7'b0010011};
                1: w = {7'b0000000, w[24:15], 3'b000, w[11:7], 7'b0110011};
                2: w = {w[31:12], 5'd0, 7'b0010011} & 32'hFFFF8FFF;
                default: ;
            endcase
            run_instr(w, $urandom_range(0, TO), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_gap_busy", busy, 0);
            end
        end

        // Reset during WAIT
        instr_valid = 1'b1;
        instr       = 32'hFFF08293;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_aluop", alu_op, ALU_NONE);
        chk("midrst_wren", regfile_wr_en, 0);
        chk("midrst_timeout", timeout_err, 0);
        exp_timeout = 1'b0;
        exp_instret = 32'd0;
        chk_instret();
        @(negedge clk);
        reset        = 1'b0;
        result_ready = 1'b1;
        alu_result   = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_write_after_rst", regfile_wr_en, 0);
            chk("idle_after_rst", busy, 0);
        end
        result_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
